psum_accumulator: RTL and testbench

Multi-pass partial-sum accumulator sitting directly upstream of the output scaler. Receives one vector of signed partial sums per accepted beat from the PE array, accumulates them per element across a configured number of input-channel passes, optionally seeded with a per-element bias, and presents the saturated `elementWidth`-bit result vector to the scaler through a valid/ready handshake. Provides full throughput: one result per `cfg_num_passes_i` accepted beats, with no bubble between output groups.

---
 rtl/psum_accumulator.sv | 141 ++++++++++++++
 tb/tb_psum_accumulator.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Multi-pass partial-sum accumulator feeding the output scaler.
// Per-lane saturating accumulation over N passes with optional bias seed.
module psum_accumulator #(
  parameter int numElements  = 4,
  parameter int psumWidth    = 16,
  parameter int elementWidth = 20,
  parameter int passCntWidth = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [passCntWidth-1:0]             cfg_num_passes_i,
  input  logic                                cfg_bias_en_i,
  input  logic [numElements*elementWidth-1:0] bias_i,
  input  logic                                clear_i,
  input  logic                                psum_valid_i,
  output logic                                psum_ready_o,
  input  logic [numElements*psumWidth-1:0]    psum_i,
  output logic                                wx_valid_o,
  input  logic                                wx_ready_i,
  output logic [numElements*elementWidth-1:0] wx_o,
  output logic                                busy_o,
  output logic                                overflow_o
);

  localparam int NE  = numElements;
  localparam int PW  = psumWidth;
  localparam int EW  = elementWidth;
  localparam int PCW = passCntWidth;

  localparam logic signed [EW:0] SMAX =
    {2'b00, {(EW-1){1'b1}}};
  localparam logic signed [EW:0] SMIN =
    {2'b11, {(EW-1){1'b0}}};

  logic [PCW-1:0]    pass_cnt_q, pass_cnt_d;
  logic [PCW-1:0]    num_passes_q, num_passes_d;
  logic              bias_en_q, bias_en_d;
  logic [NE*EW-1:0]  acc_q, acc_d;
  logic [NE*EW-1:0]  wx_q, wx_d;
  logic              wx_valid_q, wx_valid_d;
  logic              ovf_q, ovf_d;

  logic              first;
  logic              accept;
  logic              last;
  logic [PCW-1:0]    np_eff;
  logic              be_eff;
  logic [PCW:0]      cnt_inc;
  logic [NE*EW-1:0]  sat_vec;
  logic [NE-1:0]     lane_sat;

  assign psum_ready_o = !wx_valid_q || wx_ready_i;
  assign accept       = psum_valid_i && psum_ready_o;
  assign first        = (pass_cnt_q == '0);

  assign np_eff = !first ? num_passes_q :
                  (cfg_num_passes_i == '0) ? PCW'(1) :
                  cfg_num_passes_i;
  assign be_eff = first ? cfg_bias_en_i : bias_en_q;

  assign cnt_inc = {1'b0, pass_cnt_q} + {{PCW{1'b0}}, 1'b1};
  assign last    = (cnt_inc >= {1'b0, np_eff});

  genvar g;
  for (g = 0; g < NE; g++) begin : g_lane
    logic signed [EW-1:0] base;
    logic signed [EW:0]   sum;

    assign base = !first ? acc_q[g*EW +: EW] :
                  be_eff ? bias_i[g*EW +: EW] :
                  '0;
    assign sum = {base[EW-1], base} +
      {{(EW+1-PW){psum_i[g*PW+PW-1]}},
       psum_i[g*PW +: PW]};
    assign lane_sat[g] = (sum > SMAX) || (sum < SMIN);
    assign sat_vec[g*EW +: EW] =
      (sum > SMAX) ? SMAX[EW-1:0] :
      (sum < SMIN) ? SMIN[EW-1:0] :
      sum[EW-1:0];
  end

  // Next-state: clear wins, then beat acceptance, then output drain.
  always_comb begin
    pass_cnt_d   = pass_cnt_q;
    num_passes_d = num_passes_q;
    bias_en_d    = bias_en_q;
    acc_d        = acc_q;
    wx_d         = wx_q;
    wx_valid_d   = wx_valid_q;
    ovf_d        = ovf_q;
    if (clear_i) begin
      pass_cnt_d = '0;
      wx_valid_d = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      if (wx_ready_i) wx_valid_d = 1'b0;
      if (accept) begin
        if (first) begin
          num_passes_d = np_eff;
          bias_en_d    = cfg_bias_en_i;
        end
        if (|lane_sat) ovf_d = 1'b1;
        if (last) begin
          wx_d       = sat_vec;
          wx_valid_d = 1'b1;
          pass_cnt_d = '0;
        end else begin
          acc_d      = sat_vec;
          pass_cnt_d = cnt_inc[PCW-1:0];
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt_q   <= '0;
      num_passes_q <= PCW'(1);
      bias_en_q    <= 1'b0;
      acc_q        <= '0;
      wx_q         <= '0;
      wx_valid_q   <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      pass_cnt_q   <= pass_cnt_d;
      num_passes_q <= num_passes_d;
      bias_en_q    <= bias_en_d;
      acc_q        <= acc_d;
      wx_q         <= wx_d;
      wx_valid_q   <= wx_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign wx_o       = wx_q;
  assign wx_valid_o = wx_valid_q;
  assign overflow_o = ovf_q;
  assign busy_o     = (pass_cnt_q != '0) || wx_valid_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: spec-level model plus directed vectors.
// Model checked every cycle; literal values pin key results.
module tb_psum_accumulator;

  localparam int NE = 4;
  localparam int PW = 16;
  localparam int EW = 20;
  localparam int MAXV = 524287;
  localparam int MINV = -524288;

  logic clk;
  logic rst;
  logic clr;
  logic pv;
  logic wxr;
  int   cfgn;
  logic cfgb;
  int   bias_v [NE];
  int   ps_v [NE];

  logic [NE*EW-1:0] bias;
  logic [NE*PW-1:0] psum;
  logic             psum_ready;
  logic             wx_valid;
  logic [NE*EW-1:0] wx;
  logic             busy;
  logic             ovf;

  int n_chk;
  int n_pass;

  always_comb begin
    bias = '0;
    psum = '0;
    for (int i = 0; i < NE; i++) begin
      bias[i*EW +: EW] = bias_v[i][EW-1:0];
      psum[i*PW +: PW] = ps_v[i][PW-1:0];
    end
  end

  psum_accumulator dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_num_passes_i (cfgn[7:0]),
    .cfg_bias_en_i    (cfgb),
    .bias_i           (bias),
    .clear_i          (clr),
    .psum_valid_i     (pv),
    .psum_ready_o     (psum_ready),
    .psum_i           (psum),
    .wx_valid_o       (wx_valid),
    .wx_ready_i       (wxr),
    .wx_o             (wx),
    .busy_o           (busy),
    .overflow_o       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    int              cnt;
    int              np;
    bit              be;
    bit              valid;
    bit              ovf;
    bit [NE-1:0][31:0] acc;
    bit [NE-1:0][31:0] out;
  } model_t;

  model_t m;

  function automatic model_t rst_model();
    model_t r;
    r = '0;
    r.np = 1;
    return r;
  endfunction

  // Spec-level next state: group bookkeeping with plain integers.
  function automatic model_t nxt(model_t c);
    model_t n;
    bit take;
    int base;
    int s;
    n = c;
    if (clr) begin
      n.cnt = 0;
      n.valid = 0;
      n.ovf = 0;
      return n;
    end
    take = pv && (!c.valid || wxr);
    if (wxr) n.valid = 0;
    if (take) begin
      if (c.cnt == 0) begin
        n.np = (cfgn == 0) ? 1 : cfgn;
        n.be = cfgb;
      end
      for (int i = 0; i < NE; i++) begin
        if (c.cnt == 0) base = n.be ? bias_v[i] : 0;
        else base = int'(c.acc[i]);
        s = base + ps_v[i];
        if (s > MAXV) begin
          s = MAXV;
          n.ovf = 1;
        end else if (s < MINV) begin
          s = MINV;
          n.ovf = 1;
        end
        if (c.cnt + 1 < n.np) n.acc[i] = s;
        else n.out[i] = s;
      end
      if (c.cnt + 1 < n.np) begin
        n.cnt = c.cnt + 1;
      end else begin
        n.cnt = 0;
        n.valid = 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= rst_model();
    else m <= nxt(m);
  end

  task automatic chk(string nm, longint got, longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, got, exp);
  endtask

  function automatic int lane(int i);
    logic [EW-1:0] v;
    v = wx[i*EW +: EW];
    return int'($signed(v));
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", longint'(psum_ready),
          longint'(!m.valid || wxr));
      chk("valid", longint'(wx_valid),
          longint'(m.valid));
      chk("busy", longint'(busy),
          longint'(m.cnt != 0 || m.valid));
      chk("ovf", longint'(ovf), longint'(m.ovf));
      if (m.valid)
        for (int i = 0; i < NE; i++)
          chk($sformatf("wx[%0d]", i),
              longint'(lane(i)),
              longint'(int'(m.out[i])));
    end
  end

  task automatic set_ps(int a, int b, int c, int d);
    ps_v[0] = a;
    ps_v[1] = b;
    ps_v[2] = c;
    ps_v[3] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(int a, int b, int c, int d);
    pv = 1'b1;
    set_ps(a, b, c, d);
    step();
  endtask

  task automatic idle();
    pv = 1'b0;
    set_ps(0, 0, 0, 0);
    step();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    clr = 1'b0;
    pv = 1'b0;
    wxr = 1'b1;
    cfgn = 1;
    cfgb = 1'b0;
    for (int i = 0; i < NE; i++) begin
      bias_v[i] = 0;
      ps_v[i] = 0;
    end
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ready", longint'(psum_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_valid", longint'(wx_valid), 0);
    chk("rst_wx", longint'(wx), 0);

    // Basic accumulate over 3 passes.
    cfgn = 3;
    beat(5, 1, 0, 0);
    beat(-2, 2, 0, 0);
    beat(10, 3, 0, 0);
    chk("basic_lane0", lane(0), 13);
    chk("basic_lane1", lane(1), 6);
    chk("basic_valid", longint'(wx_valid), 1);
    idle();
    chk("basic_one_cycle", longint'(wx_valid), 0);

    // Bias seed; config change mid-group ignored.
    cfgn = 2;
    cfgb = 1'b1;
    bias_v[0] = 7;
    bias_v[1] = 100;
    bias_v[3] = -5;
    beat(0, -30, 0, 0);
    cfgb = 1'b0;
    cfgn = 5;
    beat(0, -80, 0, 0);
    chk("bias_lane1", lane(1), -10);
    chk("bias_lane0", lane(0), 7);
    chk("bias_lane3", lane(3), -5);
    cfgn = 1;
    beat(0, 4, 0, 0);
    chk("bias_off_next", lane(1), 4);
    idle();

    // Positive and negative saturation.
    cfgn = 40;
    repeat (40) beat(0, 0, 32767, 0);
    chk("sat_pos", lane(2), 524287);
    chk("sat_ovf", longint'(ovf), 1);
    idle();
    chk("sat_ovf_sticky", longint'(ovf), 1);
    repeat (40) beat(0, 0, -32768, 0);
    chk("sat_neg", lane(2), -524288);
    clr = 1'b1;
    idle();
    clr = 1'b0;
    chk("ovf_cleared", longint'(ovf), 0);

    // Backpressure with single-pass groups.
    cfgn = 1;
    beat(11, 0, 0, 0);
    chk("bp_first", lane(0), 11);
    wxr = 1'b0;
    pv = 1'b1;
    set_ps(22, 0, 0, 0);
    #1;
    chk("bp_ready_low", longint'(psum_ready), 0);
    repeat (3) step();
    chk("bp_hold", lane(0), 11);
    wxr = 1'b1;
    #1;
    chk("bp_ready_rel", longint'(psum_ready), 1);
    step();
    chk("bp_next", lane(0), 22);
    beat(33, 0, 0, 0);
    chk("bp_third", lane(0), 33);
    idle();

    // Clear mid-group drops partial sums and the clearing beat.
    cfgn = 4;
    beat(1, 0, 0, 0);
    beat(1, 0, 0, 0);
    clr = 1'b1;
    beat(1, 0, 0, 0);
    clr = 1'b0;
    pv = 1'b0;
    chk("clr_busy", longint'(busy), 0);
    chk("clr_valid", longint'(wx_valid), 0);
    repeat (4) beat(1, 0, 0, 0);
    chk("clr_sum", lane(0), 4);
    idle();

    // Zero passes behaves as one.
    cfgn = 0;
    beat(9, 0, 0, 0);
    chk("zero_pass", lane(0), 9);
    chk("zero_valid", longint'(wx_valid), 1);
    idle();

    // Asynchronous reset between edges mid-group.
    cfgn = 3;
    beat(50, 0, 0, 0);
    beat(60, 0, 0, 0);
    pv = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", longint'(busy), 0);
    chk("arst_valid", longint'(wx_valid), 0);
    chk("arst_ready", longint'(psum_ready), 1);
    chk("arst_wx", longint'(wx), 0);
    step();
    rst = 1'b0;
    cfgn = 2;
    beat(3, 0, 0, 0);
    beat(4, 0, 0, 0);
    chk("post_rst", lane(0), 7);
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
